bit_scanner: RTL

Multi-cycle, parametrised bit-vector scanner that computes population count, lowest-set position, highest-set position and trailing-ones run length of a wide vector. It processes the vector CHUNK bits per cycle behind a valid/ready request/response handshake. It serves free-list, ROB-occupancy and mask-accounting logic whose vectors are too wide for single-cycle combinational counting.

---
 rtl/bit_scanner.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bit_scanner.sv
// Multi-cycle bit-vector scanner: popcount, lowest/highest set position and trailing-ones
// run, consuming CHUNK bits per cycle behind a valid/ready request/response handshake.
module bit_scanner #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CHUNK = 32,
    localparam int unsigned NCHUNK = WIDTH / CHUNK,
    localparam int unsigned IW = $clog2(WIDTH + 1),
    localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_req_vld,
    output logic             o_req_rdy,
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_resp_vld,
    input  logic             i_resp_rdy,
    output logic [IW-1:0]    o_popcnt,
    output logic [IW-1:0]    o_first_pos,
    output logic [IW-1:0]    o_lead_pos,
    output logic [IW-1:0]    o_trail_ones
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CW-1:0]    k_q, k_d;
    logic [IW-1:0]    pop_q, pop_d, first_q, first_d, lead_q, lead_d, trail_q, trail_d;
    logic             found_q, found_d, broken_q, broken_d;
    logic [IW-1:0]    res_pop_q, res_first_q, res_lead_q, res_trail_q;
    logic             load_res;

    // Per-chunk statistics of the current low chunk (vec_q is shifted down each cycle).
    logic [CHUNK-1:0] chunk;
    logic [IW-1:0]    c_pop, c_lo, c_hi, c_trail, base;
    logic             c_nz, c_all, run;

    always_comb begin
        chunk   = vec_q[CHUNK-1:0];
        c_pop   = '0;
        c_lo    = '0;
        c_hi    = '0;
        c_trail = '0;
        run     = 1'b1;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (chunk[i]) begin
                c_pop = c_pop + IW'(1);
                c_hi  = IW'(i);
            end
            if (run && chunk[i]) c_trail = c_trail + IW'(1);
            else run = 1'b0;
        end
        for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
            if (chunk[i]) c_lo = IW'(i);
        end
        c_nz  = |chunk;
        c_all = &chunk;
        base  = IW'(k_q * CHUNK);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        k_d      = k_q;
        pop_d    = pop_q;
        first_d  = first_q;
        lead_d   = lead_q;
        trail_d  = trail_q;
        found_d  = found_q;
        broken_d = broken_q;
        load_res = 1'b0;
        if (i_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req_vld) begin
                        vec_d    = i_vec;
                        k_d      = '0;
                        pop_d    = '0;
                        first_d  = '0;
                        lead_d   = '0;
                        trail_d  = '0;
                        found_d  = 1'b0;
                        broken_d = 1'b0;
                        state_d  = StScan;
                    end
                end
                StScan: begin
                    pop_d = pop_q + c_pop;
                    if (!found_q && c_nz) begin
                        first_d = base + c_lo + IW'(1);
                        found_d = 1'b1;
                    end
                    // Ascending chunk order makes the last nonzero chunk win.
                    if (c_nz) lead_d = base + c_hi + IW'(1);
                    if (!broken_q) begin
                        trail_d = trail_q + c_trail;
                        if (!c_all) broken_d = 1'b1;
                    end
                    vec_d = vec_q >> CHUNK;
                    if (k_q == CW'(NCHUNK - 1)) begin
                        state_d  = StDone;
                        load_res = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (i_resp_rdy) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            k_q         <= '0;
            pop_q       <= '0;
            first_q     <= '0;
            lead_q      <= '0;
            trail_q     <= '0;
            found_q     <= 1'b0;
            broken_q    <= 1'b0;
            res_pop_q   <= '0;
            res_first_q <= '0;
            res_lead_q  <= '0;
            res_trail_q <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            k_q      <= k_d;
            pop_q    <= pop_d;
            first_q  <= first_d;
            lead_q   <= lead_d;
            trail_q  <= trail_d;
            found_q  <= found_d;
            broken_q <= broken_d;
            // Results live in their own registers so they hold between responses.
            if (load_res) begin
                res_pop_q   <= pop_d;
                res_first_q <= first_d;
                res_lead_q  <= lead_d;
                res_trail_q <= trail_d;
            end
        end
    end

    assign o_req_rdy    = (state_q == StIdle);
    assign o_resp_vld   = (state_q == StDone);
    assign o_popcnt     = res_pop_q;
    assign o_first_pos  = res_first_q;
    assign o_lead_pos   = res_lead_q;
    assign o_trail_ones = res_trail_q;

endmodule
